// File: rtl/ps2_kbd_cmd_controller_pkg.sv
// Shared constants and state encodings for the PS/2 keyboard command path.
// Used by the controller, its timer and its interface users.
package ps2_kbd_pkg;

  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_ACK = 2'd2,
    ST_WAIT_BAT = 2'd3
  } kbd_state_t;

  typedef enum logic {
    SEQ_LED = 1'b0,
    SEQ_RST = 1'b1
  } kbd_seq_t;

  function automatic int unsigned max_u(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ps2_kbd_cmd_controller_if.sv
// Bundle of every non-clock signal of the keyboard command controller.
// master: the controller itself; slave: receiver/transmitter/host side.
interface ps2_kbd_cmd_controller_if;

  logic       rx_en;
  logic [7:0] rx_data;
  logic       fwd_en;
  logic [7:0] fwd_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       led_req;
  logic [2:0] led_state;
  logic       kbd_rst_req;
  logic       cmd_busy;
  logic       kbd_ok;
  logic       err;

  modport master (
    input  rx_en, rx_data,
    input  tx_busy,
    input  led_req, led_state,
    input  kbd_rst_req,
    output fwd_en, fwd_data,
    output tx_start, tx_data,
    output cmd_busy, kbd_ok, err
  );

  modport slave (
    output rx_en, rx_data,
    output tx_busy,
    output led_req, led_state,
    output kbd_rst_req,
    input  fwd_en, fwd_data,
    input  tx_start, tx_data,
    input  cmd_busy, kbd_ok, err
  );

endinterface

// File: rtl/ps2_kbd_cmd_controller_timer.sv
// ps2_resp_timer: loadable down-counter; o_expire holds high at zero.
// Ports: i_clk, i_reset (sync high), i_load/i_load_val, i_clr, o_expire.
module ps2_resp_timer #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_clr,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;
  logic         r_run;

  // Expiry stays asserted until cleared or reloaded, so a timeout
  // masked by a same-cycle byte is still seen one cycle later.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
      r_run <= 1'b1;
    end else if (i_clr) begin
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (r_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = r_run && (r_cnt == '0);

endmodule

// File: rtl/ps2_kbd_cmd_controller.sv
// Host-side PS/2 keyboard command sequencer (LED set 0xED+arg, reset 0xFF).
// Ports: clk, reset (sync high), bus (ps2_kbd_cmd_controller_if.master):
//   rx_en/rx_data in, fwd_en/fwd_data out, tx_start/tx_data out, tx_busy in,
//   led_req/led_state/kbd_rst_req in, cmd_busy/kbd_ok/err out.
// Option: KBD_AUTO_INIT_EN starts a keyboard reset sequence out of reset.
module ps2_kbd_cmd_controller
  import ps2_kbd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC     = 2_000_000,
  parameter int unsigned BAT_TIMEOUT_CYC = 100_000_000,
  parameter int unsigned MAX_RETRY       = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  ps2_kbd_cmd_controller_if.master bus
);

  localparam int unsigned TW =
    $clog2(max_u(TIMEOUT_CYC, BAT_TIMEOUT_CYC) + 1);
  localparam int unsigned RW =
    (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] ACK_LOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] BAT_LOAD = TW'(BAT_TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

`ifdef KBD_AUTO_INIT_EN
  localparam logic RST_PEND_INIT = 1'b1;
`else
  localparam logic RST_PEND_INIT = 1'b0;
`endif

  kbd_state_t    r_state;
  kbd_seq_t      r_seq;
  logic          r_arg_phase;
  logic [RW-1:0] r_retry;
  logic [2:0]    r_led_arg;
  logic          r_pend_led;
  logic          r_pend_rst;
  logic          r_tx_start;
  logic [7:0]    r_tx_data;
  logic          r_fwd_en;
  logic [7:0]    r_fwd_data;
  logic          r_kbd_ok;
  logic          r_err;

  logic          w_ack;
  logic          w_nak;
  logic          w_bat_ok;
  logic          w_bat_fail;
  logic          w_in_ack;
  logic          w_in_bat;
  logic          w_consume;
  logic          w_fwd;
  logic          w_expire;
  logic          w_ack_fail;
  logic          w_bat_err;
  logic          w_tmr_load;
  logic          w_tmr_clr;
  logic [TW-1:0] w_tmr_val;

  assign w_ack      = bus.rx_en && (bus.rx_data == RSP_ACK);
  assign w_nak      = bus.rx_en && (bus.rx_data == RSP_RESEND);
  assign w_bat_ok   = bus.rx_en && (bus.rx_data == RSP_BAT_OK);
  assign w_bat_fail = bus.rx_en && (bus.rx_data == RSP_BAT_FAIL);
  assign w_in_ack   = (r_state == ST_WAIT_ACK);
  assign w_in_bat   = (r_state == ST_WAIT_BAT);

  // Only responses the sequencer is waiting for are swallowed.
  assign w_consume = (w_in_ack && (w_ack || w_nak)) ||
                     (w_in_bat && (w_bat_ok || w_bat_fail));
  assign w_fwd     = bus.rx_en && !w_consume;

  // A received byte always beats a same-cycle timeout.
  assign w_ack_fail = w_in_ack &&
                      (w_nak || (!bus.rx_en && w_expire));
  assign w_bat_err  = w_in_bat &&
                      (w_bat_fail || (!bus.rx_en && w_expire));

  assign w_tmr_load = ((r_state == ST_SEND) && !bus.tx_busy) ||
                      (w_in_ack && w_ack && (r_seq == SEQ_RST));
  assign w_tmr_val  = (r_state == ST_SEND) ? ACK_LOAD : BAT_LOAD;
  assign w_tmr_clr  = (r_state == ST_IDLE);

  ps2_resp_timer #(
    .W (TW)
  ) u_tmr (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_clr      (w_tmr_clr),
    .o_expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_seq       <= SEQ_LED;
      r_arg_phase <= 1'b0;
      r_retry     <= '0;
      r_led_arg   <= '0;
      r_pend_led  <= 1'b0;
      r_pend_rst  <= RST_PEND_INIT;
      r_tx_start  <= 1'b0;
      r_tx_data   <= '0;
      r_fwd_en    <= 1'b0;
      r_fwd_data  <= '0;
      r_kbd_ok    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      r_err      <= 1'b0;
      r_fwd_en   <= w_fwd;
      if (w_fwd) r_fwd_data <= bus.rx_data;
      if (bus.led_req)     r_pend_led <= 1'b1;
      if (bus.kbd_rst_req) r_pend_rst <= 1'b1;

      unique case (r_state)
        ST_IDLE: begin
`ifndef KBD_AUTO_INIT_EN
          if (w_bat_ok) r_kbd_ok <= 1'b1;
`endif
          // A request arriving as its flag is consumed stays pending.
          if (r_pend_rst) begin
            r_pend_rst  <= bus.kbd_rst_req;
            r_seq       <= SEQ_RST;
            r_arg_phase <= 1'b0;
            r_retry     <= '0;
            r_tx_data   <= CMD_RESET;
            r_state     <= ST_SEND;
          end else if (r_pend_led) begin
            r_pend_led  <= bus.led_req;
            r_seq       <= SEQ_LED;
            r_led_arg   <= bus.led_state;
            r_arg_phase <= 1'b0;
            r_retry     <= '0;
            r_tx_data   <= CMD_SET_LED;
            r_state     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (!bus.tx_busy) begin
            r_tx_start <= 1'b1;
            r_state    <= ST_WAIT_ACK;
          end
        end

        ST_WAIT_ACK: begin
          unique case (1'b1)
            w_ack: begin
              if (r_seq == SEQ_RST) begin
                r_state <= ST_WAIT_BAT;
              end else if (!r_arg_phase) begin
                r_arg_phase <= 1'b1;
                r_retry     <= '0;
                r_tx_data   <= {5'b0, r_led_arg};
                r_state     <= ST_SEND;
              end else begin
                r_kbd_ok <= 1'b1;
                r_state  <= ST_IDLE;
              end
            end
            w_ack_fail: begin
              if (r_retry == RETRY_MAX) begin
                r_err    <= 1'b1;
                r_kbd_ok <= 1'b0;
                r_state  <= ST_IDLE;
              end else begin
                // tx_data still holds the byte to resend.
                r_retry <= r_retry + 1'b1;
                r_state <= ST_SEND;
              end
            end
            default: ;
          endcase
        end

        ST_WAIT_BAT: begin
          unique case (1'b1)
            w_bat_ok: begin
              r_kbd_ok <= 1'b1;
              r_state  <= ST_IDLE;
            end
            w_bat_err: begin
              r_err    <= 1'b1;
              r_kbd_ok <= 1'b0;
              r_state  <= ST_IDLE;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign bus.fwd_en   = r_fwd_en;
  assign bus.fwd_data = r_fwd_data;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bus.cmd_busy = (r_state != ST_IDLE);
  assign bus.kbd_ok   = r_kbd_ok;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_ps2_kbd_cmd_controller.sv
// Self-checking bench for ps2_kbd_cmd_controller: the bench plays the
// keyboard, and a transaction-level model predicts bytes, errors, kbd_ok.
module tb_ps2_kbd_cmd_controller;
  import ps2_kbd_pkg::*;

  localparam int TO = 50;
  localparam int BT = 200;
  localparam int MR = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ps2_kbd_cmd_controller_if bus ();

  ps2_kbd_cmd_controller #(
    .TIMEOUT_CYC     (TO),
    .BAT_TIMEOUT_CYC (BT),
    .MAX_RETRY       (MR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_err_pulse = 0;
  int m_err = 0;
  bit m_ok = 1'b0;

  logic [7:0] q_tx[$];
  logic [7:0] q_fwd[$];
  logic [7:0] m_fwd[$];
  logic [7:0] m_tx[$];
  int         m_rsp[$];

  always @(negedge clk) begin
    if (bus.tx_start) q_tx.push_back(bus.tx_data);
    if (bus.fwd_en) q_fwd.push_back(bus.fwd_data);
    if (bus.err) n_err_pulse++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic rx(input logic [7:0] b);
    bus.rx_en   = 1'b1;
    bus.rx_data = b;
    tick();
    bus.rx_en   = 1'b0;
  endtask

  task automatic noise();
    logic [7:0] b;
    do b = 8'($urandom);
    while (b inside {RSP_ACK, RSP_RESEND, RSP_BAT_OK, RSP_BAT_FAIL});
    m_fwd.push_back(b);
    rx(b);
  endtask

  task automatic wait_tx(input string tag, input logic [7:0] exp,
                         input int budget);
    int n = 0;
    while (q_tx.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    if (q_tx.size() == 0) chk({tag, "_none"}, q_tx.size(), 1);
    else chk(tag, q_tx.pop_front(), exp);
  endtask

  task automatic chk_fwd(input string tag);
    chk({tag, "_fwd_n"}, q_fwd.size(), m_fwd.size());
    while (q_fwd.size() > 0 && m_fwd.size() > 0)
      chk({tag, "_fwd"}, q_fwd.pop_front(), m_fwd.pop_front());
    q_fwd.delete();
    m_fwd.delete();
  endtask

  // Model: a byte with nk failed attempts is sent min(nk,MR)+1 times;
  // nk > MR aborts the whole command with an error.
  task automatic run_cmd(input bit is_rst, input logic [2:0] st,
                         input int nak0, input int nak1, input int bat,
                         input bit trig, input bit silent_ok,
                         input bit settle);
    logic [7:0] bytes[2];
    int nb;
    int nk;
    int att;
    int e0;
    bit fails;
    string tg;
    fails = 1'b0;
    m_tx.delete();
    m_rsp.delete();
    bytes[0] = is_rst ? CMD_RESET : CMD_SET_LED;
    bytes[1] = {5'b0, st};
    nb = is_rst ? 1 : 2;
    tg = is_rst ? "tx_rst" : "tx_led";
    for (int j = 0; j < nb && !fails; j++) begin
      nk  = (j == 0) ? nak0 : nak1;
      att = (nk > MR) ? MR + 1 : nk + 1;
      for (int a = 0; a < att; a++) begin
        m_tx.push_back(bytes[j]);
        if (a < nk)
          m_rsp.push_back((silent_ok && $urandom_range(1, 0) == 1) ?
                          -1 : int'(RSP_RESEND));
        else
          m_rsp.push_back(int'(RSP_ACK));
      end
      if (nk > MR) fails = 1'b1;
    end
    if (trig) begin
      if (is_rst) bus.kbd_rst_req = 1'b1;
      else begin
        bus.led_state = st;
        bus.led_req = 1'b1;
      end
      tick();
      bus.kbd_rst_req = 1'b0;
      bus.led_req = 1'b0;
    end
    for (int i = 0; i < m_tx.size(); i++) begin
      wait_tx(tg, m_tx[i], TO + 20);
      if (i == 0 && !is_rst) bus.led_state = 3'($urandom);
      if (m_rsp[i] >= 0) begin
        if ($urandom_range(2, 0) == 0) noise();
        rx(8'(m_rsp[i]));
      end
    end
    if (fails) begin
      if (m_rsp[m_rsp.size()-1] < 0) tick(TO + 5);
      m_err++;
      m_ok = 1'b0;
    end else if (is_rst) begin
      if ($urandom_range(1, 0) == 1) noise();
      case (bat)
        0: begin
          rx(RSP_BAT_OK);
          m_ok = 1'b1;
        end
        1: begin
          rx(RSP_BAT_FAIL);
          m_err++;
          m_ok = 1'b0;
        end
        default: begin
          e0 = n_err_pulse;
          tick(BT - 15);
          chk("bat_early_err", n_err_pulse, e0);
          tick(30);
          m_err++;
          m_ok = 1'b0;
        end
      endcase
    end else begin
      m_ok = 1'b1;
    end
    chk({tg, "_err_cnt"}, n_err_pulse, m_err);
    chk({tg, "_kbd_ok"}, bus.kbd_ok, m_ok);
    chk_fwd(tg);
    if (settle) begin
      tick(5);
      chk({tg, "_idle"}, bus.cmd_busy, 0);
      chk({tg, "_no_extra_tx"}, q_tx.size(), 0);
    end
  endtask

  initial begin
    bus.rx_en = 1'b0;
    bus.rx_data = '0;
    bus.tx_busy = 1'b0;
    bus.led_req = 1'b0;
    bus.led_state = '0;
    bus.kbd_rst_req = 1'b0;
    tick(3);
    chk("rst_fwd_en", bus.fwd_en, 0);
    chk("rst_fwd_data", bus.fwd_data, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_cmd_busy", bus.cmd_busy, 0);
    chk("rst_kbd_ok", bus.kbd_ok, 0);
    chk("rst_err", bus.err, 0);
    reset = 1'b0;

`ifdef KBD_AUTO_INIT_EN
    run_cmd(1, 3'b000, 0, 0, 0, 0, 0, 1);
`else
    tick(5);
    chk("noauto_kbd_ok", bus.kbd_ok, 0);
    chk("noauto_no_tx", q_tx.size(), 0);
    m_fwd.push_back(RSP_BAT_OK);
    rx(RSP_BAT_OK);
    m_ok = 1'b1;
    chk("spont_aa_kbd_ok", bus.kbd_ok, m_ok);
    chk_fwd("spont_aa");
`endif

    // Plain forwarding in IDLE.
    rx(8'h1C);
    chk("fwd1_en", bus.fwd_en, 1);
    chk("fwd1_data", bus.fwd_data, 8'h1C);
    tick();
    chk("fwd1_en_drop", bus.fwd_en, 0);
    q_fwd.delete();
    m_fwd.push_back(8'hF0);
    m_fwd.push_back(8'h1C);
    rx(8'hF0);
    rx(8'h1C);
    chk_fwd("fwd2");

    // LED update, then a LED update that runs out of resends.
    run_cmd(0, 3'b101, 0, 0, 0, 1, 0, 1);
    run_cmd(0, 3'b110, 3, 0, 0, 1, 0, 1);

    // Reset: good BAT, failed BAT, missing BAT.
    run_cmd(1, 3'b000, 0, 0, 0, 1, 0, 1);
    run_cmd(1, 3'b000, 0, 0, 1, 1, 0, 1);
    run_cmd(1, 3'b000, 0, 0, 2, 1, 0, 1);

    // Both requests together behind a busy transmitter.
    bus.tx_busy = 1'b1;
    bus.led_state = 3'b011;
    bus.led_req = 1'b1;
    bus.kbd_rst_req = 1'b1;
    tick();
    bus.led_req = 1'b0;
    bus.kbd_rst_req = 1'b0;
    tick(10);
    chk("busy_hold_no_tx", q_tx.size(), 0);
    chk("busy_hold_cmd_busy", bus.cmd_busy, 1);
    bus.tx_busy = 1'b0;
    run_cmd(1, 3'b011, 0, 0, 0, 0, 0, 0);
    run_cmd(0, 3'b011, 0, 0, 0, 0, 0, 1);

    // Randomized command mix against the model.
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        noise();
        chk_fwd("rnd_idle");
      end
      run_cmd(1'($urandom_range(1, 0)), 3'($urandom),
              $urandom_range(3, 0), $urandom_range(3, 0),
              $urandom_range(2, 0), 1, 1, 1);
    end

    // Reset in the middle of an LED command with a reset pending.
    bus.led_state = 3'b111;
    bus.led_req = 1'b1;
    tick();
    bus.led_req = 1'b0;
    wait_tx("mid_tx_led", CMD_SET_LED, 20);
    bus.kbd_rst_req = 1'b1;
    tick();
    bus.kbd_rst_req = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_rst_fwd_en", bus.fwd_en, 0);
    chk("mid_rst_tx_start", bus.tx_start, 0);
    chk("mid_rst_tx_data", bus.tx_data, 0);
    chk("mid_rst_cmd_busy", bus.cmd_busy, 0);
    chk("mid_rst_kbd_ok", bus.kbd_ok, 0);
    chk("mid_rst_err", bus.err, 0);
    reset = 1'b0;
    m_ok = 1'b0;
    q_tx.delete();
    q_fwd.delete();
`ifdef KBD_AUTO_INIT_EN
    run_cmd(1, 3'b000, 0, 0, 0, 0, 0, 1);
`else
    tick(TO + 30);
    chk("post_rst_no_tx", q_tx.size(), 0);
    chk("post_rst_idle", bus.cmd_busy, 0);
    chk("post_rst_err_cnt", n_err_pulse, m_err);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
